// File: rtl/fifo_pkt_write_logic_pkg.sv
// ============================================================================
//  Module      : fifo_pkt_write_logic_pkg
//  Description : Shared state encodings and helpers for the packet FIFO
//                write-side logic.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_pkt_write_logic_pkg;

    typedef logic [1:0] fws_state_t;

    localparam fws_state_t FWS_IDLE = 2'd0;
    localparam fws_state_t FWS_OPEN = 2'd1;
    localparam fws_state_t FWS_OVF  = 2'd2;

    // A truncated packet accepts no further words until it is closed.
    function automatic logic fws_accepts(input fws_state_t state);
        return state != FWS_OVF;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_gray2bin.sv
// ============================================================================
//  Module      : fifo_gray2bin
//  Description : Combinational Gray-to-binary converter, width W.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_gray2bin #(
    parameter int W = 3
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

`default_nettype wire

// File: rtl/fifo_pkt_write_logic.sv
// ============================================================================
//  Module      : fifo_pkt_write_logic
//  Description : Write-side pointer/flag logic of the async packet FIFO with
//                packet commit/drop. Optional macro FIFO_WR_OVF_CNT_EN adds
//                the saturating rejected-write counter ovf_cnt.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_pkt_write_logic
    import fifo_pkt_write_logic_pkg::*;
#(
    parameter int PTR_SZ    = 2,
    parameter int AFULL_THR = 3
`ifdef FIFO_WR_OVF_CNT_EN
   ,parameter int OVF_CW    = 8
`endif
) (
    input  logic              clk,
    input  logic              rst,          // active-low, asynchronous
    input  logic              winc,
    input  logic              wcommit,
    input  logic              wdrop,
    input  logic [PTR_SZ:0]   rq2_raddr,
    output logic              write_en,
    output logic [PTR_SZ-1:0] waddr,
    output logic [PTR_SZ:0]   waddr_gray,
    output logic              wfull,
    output logic              walmost_full,
    output logic [PTR_SZ:0]   wlevel,
    output logic              pkt_err
`ifdef FIFO_WR_OVF_CNT_EN
   ,output logic [OVF_CW-1:0] ovf_cnt
`endif
);

    localparam int c_ptr_w = PTR_SZ + 1;

    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_cptr;
    logic [c_ptr_w-1:0] r_waddr_gray;
    fws_state_t         r_state;
    logic               r_pkt_err;

    logic [c_ptr_w-1:0] w_rbin;
    logic [c_ptr_w-1:0] w_level;
    logic               w_full;
    logic               w_write_en;
    logic [c_ptr_w-1:0] w_wptr_next;
    logic [c_ptr_w-1:0] w_cptr_next;
    fws_state_t         w_state_next;
    logic               w_pkt_err_next;

    fifo_gray2bin #(.W(c_ptr_w)) u_rptr_g2b (
        .gray (rq2_raddr),
        .bin  (w_rbin)
    );

    // Level counts provisional words too, so a long packet can fill the FIFO.
    assign w_level = r_wptr - w_rbin;
    assign w_full  = (r_wptr[PTR_SZ] != w_rbin[PTR_SZ]) &&
                     (r_wptr[PTR_SZ-1:0] == w_rbin[PTR_SZ-1:0]);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr       <= '0;
            r_cptr       <= '0;
            r_waddr_gray <= '0;
            r_state      <= FWS_IDLE;
            r_pkt_err    <= 1'b0;
        end else begin
            r_wptr       <= w_wptr_next;
            r_cptr       <= w_cptr_next;
            r_waddr_gray <= w_cptr_next ^ (w_cptr_next >> 1);
            r_state      <= w_state_next;
            r_pkt_err    <= w_pkt_err_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_wptr_next    = r_wptr;
        w_cptr_next    = r_cptr;
        w_state_next   = r_state;
        w_pkt_err_next = 1'b0;
        if (r_state == FWS_OVF) begin
            if (wcommit || wdrop) begin
                w_wptr_next  = r_cptr;
                w_state_next = FWS_IDLE;
            end
        end else if (wdrop) begin
            w_wptr_next  = r_cptr;
            w_state_next = FWS_IDLE;
        end else if (winc && w_full) begin
            // Packet is truncated; a commit in this cycle must not publish it.
            w_state_next   = FWS_OVF;
            w_pkt_err_next = 1'b1;
        end else begin
            w_wptr_next = r_wptr + c_ptr_w'(w_write_en);
            if (wcommit) begin
                w_cptr_next  = w_wptr_next;
                w_state_next = FWS_IDLE;
            end else if (w_write_en) begin
                w_state_next = FWS_OPEN;
            end
        end
    end

    // Output logic
    always_comb begin
        w_write_en = winc & ~w_full & ~wdrop & fws_accepts(r_state);
    end

    assign write_en     = w_write_en;
    assign waddr        = r_wptr[PTR_SZ-1:0];
    assign waddr_gray   = r_waddr_gray;
    assign wfull        = w_full;
    assign walmost_full = (w_level >= c_ptr_w'(AFULL_THR));
    assign wlevel       = w_level;
    assign pkt_err      = r_pkt_err;

`ifdef FIFO_WR_OVF_CNT_EN
    logic              w_reject;
    logic [OVF_CW-1:0] r_ovf_cnt;

    assign w_reject = winc & ((r_state == FWS_OVF) | (w_full & ~wdrop));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf_cnt <= '0;
        end else if (w_reject && (r_ovf_cnt != '1)) begin
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_pkt_write_logic.sv
// ============================================================================
//  Module      : tb_fifo_pkt_write_logic
//  Description : Self-checking bench for fifo_pkt_write_logic (PTR_SZ=2).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_pkt_write_logic;

    logic       clk = 1'b0;
    logic       rst;
    logic       winc, wcommit, wdrop;
    logic [2:0] rq2_raddr;
    logic       write_en, wfull, walmost_full, pkt_err;
    logic [1:0] waddr;
    logic [2:0] waddr_gray, wlevel;
`ifdef FIFO_WR_OVF_CNT_EN
    logic [7:0] ovf_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_pkt_write_logic #(.PTR_SZ(2), .AFULL_THR(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .winc         (winc),
        .wcommit      (wcommit),
        .wdrop        (wdrop),
        .rq2_raddr    (rq2_raddr),
        .write_en     (write_en),
        .waddr        (waddr),
        .waddr_gray   (waddr_gray),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .pkt_err      (pkt_err)
`ifdef FIFO_WR_OVF_CNT_EN
       ,.ovf_cnt      (ovf_cnt)
`endif
    );

    typedef struct {
        logic       winc, wcommit, wdrop;
        logic [2:0] rq2;
        logic       we;
        logic [1:0] waddr;
        logic [2:0] wgray;
        logic       full, afull;
        logic [2:0] lvl;
        logic       perr;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input int wi, wc, wd, rq, we, wa, wg, f, af, l, pe);
        vec_t v;
        v.winc = wi[0]; v.wcommit = wc[0]; v.wdrop = wd[0]; v.rq2 = rq[2:0];
        v.we = we[0]; v.waddr = wa[1:0]; v.wgray = wg[2:0];
        v.full = f[0]; v.afull = af[0]; v.lvl = l[2:0]; v.perr = pe[0];
        return v;
    endfunction

    function automatic logic [2:0] gray3(input int b);
        logic [2:0] v;
        v = b[2:0];
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int idx, input int we, wa, wg, f, af, l, pe);
        chk({tag, "_write_en"},     idx, 32'(write_en),     32'(we));
        chk({tag, "_waddr"},        idx, 32'(waddr),        32'(wa));
        chk({tag, "_waddr_gray"},   idx, 32'(waddr_gray),   32'(wg));
        chk({tag, "_wfull"},        idx, 32'(wfull),        32'(f));
        chk({tag, "_walmost_full"}, idx, 32'(walmost_full), 32'(af));
        chk({tag, "_wlevel"},       idx, 32'(wlevel),       32'(l));
        chk({tag, "_pkt_err"},      idx, 32'(pkt_err),      32'(pe));
    endtask

    // Packet-level reference model state
    int committed, pkt_len, rptr, m_ovf_cnt;
    bit trunc, perr_exp;

    initial begin
        // fill / overflow / drop / wrap / simultaneous-control sequence
        tbl[0]  = mk(1,0,0,0, 1,0,0,0,0,0,0);
        tbl[1]  = mk(1,0,0,0, 1,1,0,0,0,1,0);
        tbl[2]  = mk(1,0,0,0, 1,2,0,0,0,2,0);
        tbl[3]  = mk(1,1,0,0, 1,3,0,0,1,3,0);
        tbl[4]  = mk(0,0,0,0, 0,0,6,1,1,4,0);
        tbl[5]  = mk(1,0,0,0, 0,0,6,1,1,4,0);
        tbl[6]  = mk(1,0,0,0, 0,0,6,1,1,4,1);
        tbl[7]  = mk(0,1,0,0, 0,0,6,1,1,4,0);
        tbl[8]  = mk(0,0,0,6, 0,0,6,0,0,0,0);
        tbl[9]  = mk(1,0,0,6, 1,0,6,0,0,0,0);
        tbl[10] = mk(1,0,0,6, 1,1,6,0,0,1,0);
        tbl[11] = mk(0,0,1,6, 0,2,6,0,0,2,0);
        tbl[12] = mk(0,0,0,6, 0,0,6,0,0,0,0);
        tbl[13] = mk(1,0,0,6, 1,0,6,0,0,0,0);
        tbl[14] = mk(1,0,0,6, 1,1,6,0,0,1,0);
        tbl[15] = mk(1,0,0,6, 1,2,6,0,0,2,0);
        tbl[16] = mk(1,1,0,6, 1,3,6,0,1,3,0);
        tbl[17] = mk(0,0,0,6, 0,0,0,1,1,4,0);
        tbl[18] = mk(0,0,0,0, 0,0,0,0,0,0,0);
        tbl[19] = mk(1,1,1,0, 0,0,0,0,0,0,0);
        tbl[20] = mk(1,1,0,0, 1,0,0,0,0,0,0);
        tbl[21] = mk(0,0,0,0, 0,1,1,0,0,1,0);

        rst = 1'b0; winc = 1'b0; wcommit = 1'b0; wdrop = 1'b0; rq2_raddr = '0;
        #12;
        chk_outs("reset", 0, 0,0,0,0,0,0,0);
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            winc = tbl[i].winc; wcommit = tbl[i].wcommit; wdrop = tbl[i].wdrop;
            rq2_raddr = tbl[i].rq2;
            #1;
            chk_outs("tbl", i, int'(tbl[i].we), int'(tbl[i].waddr), int'(tbl[i].wgray),
                     int'(tbl[i].full), int'(tbl[i].afull), int'(tbl[i].lvl), int'(tbl[i].perr));
        end
`ifdef FIFO_WR_OVF_CNT_EN
        chk("tbl_ovf_cnt", 0, 32'(ovf_cnt), 32'd2);
`endif

        // Randomised run against the packet-level model
        @(negedge clk);
        winc = 1'b0; wcommit = 1'b0; wdrop = 1'b0; rq2_raddr = '0; rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        committed = 0; pkt_len = 0; rptr = 0; m_ovf_cnt = 0; trunc = 0; perr_exp = 0;
        for (int c = 0; c < 400; c++) begin
            int wp, lvl, wi, wc, wd, we;
            bit full;
            @(negedge clk);
            if (rptr < committed && $urandom_range(0, 2) == 0) rptr++;
            wi = ($urandom_range(0, 9) < 7) ? 1 : 0;
            wc = ($urandom_range(0, 6) == 0) ? 1 : 0;
            wd = ($urandom_range(0, 19) == 0) ? 1 : 0;
            winc = wi[0]; wcommit = wc[0]; wdrop = wd[0];
            rq2_raddr = gray3(rptr % 8);
            wp   = (committed + pkt_len) % 8;
            lvl  = (wp - (rptr % 8) + 8) % 8;
            full = (committed + pkt_len - rptr) == 4;
            we   = (wi == 1 && !full && wd == 0 && !trunc) ? 1 : 0;
            #1;
            chk_outs("rnd", c, we, wp % 4, int'(gray3(committed % 8)), int'(full),
                     (lvl >= 3) ? 1 : 0, lvl, int'(perr_exp));
`ifdef FIFO_WR_OVF_CNT_EN
            chk("rnd_ovf_cnt", c, 32'(ovf_cnt), 32'(m_ovf_cnt));
`endif
            perr_exp = 0;
            if (trunc) begin
                if (wi == 1) m_ovf_cnt++;
                if (wc == 1 || wd == 1) begin pkt_len = 0; trunc = 0; end
            end else if (wd == 1) begin
                pkt_len = 0;
            end else if (wi == 1 && full) begin
                trunc = 1; perr_exp = 1; m_ovf_cnt++;
            end else begin
                pkt_len += we;
                if (wc == 1) begin committed += pkt_len; pkt_len = 0; end
            end
            if (m_ovf_cnt > 255) m_ovf_cnt = 255;
        end

        // Reset in the middle of an open packet
        @(negedge clk);
        winc = 1'b0; wcommit = 1'b0; wdrop = 1'b0; rq2_raddr = '0; rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) winc = 1'b1;
        @(negedge clk);
        @(negedge clk) winc = 1'b0;
        #1;
        chk("midrst_level_before", 0, 32'(wlevel), 32'd2);
        #1 rst = 1'b0;
        #1;
        chk("midrst_waddr", 0, 32'(waddr), 32'd0);
        chk("midrst_wlevel", 0, 32'(wlevel), 32'd0);
        chk("midrst_waddr_gray", 0, 32'(waddr_gray), 32'd0);
        @(negedge clk) rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
